ps2_key_buffer: RTL and testbench
=================================

# ps2_key_buffer

PS/2 keyboard receiver and key FIFO feeding the memory subsystem's keyboard port (load from 0xFFFFFFFF). Samples the asynchronous PS/2 clock/data lines in the CLK_CPU domain, deframes 11-bit PS/2 frames, drops release and extended-prefix codes, and queues make codes. `pressed_key` always presents the FIFO head. `clean_key_buffer` from the memory subsystem pops it.

## Interface
- `FIFO_DEPTH`, 8, number of queued scan codes; power of two, ≥2.
- `TIMEOUT_CYCLES`, 5000, CLK_CPU cycles without a PS/2 falling edge before a partial frame is abandoned.
- `CLK_CPU` input 1 — CPU clock; all state updates on its rising edge.
- `RST_N` input 1 — asynchronous, active-low reset.
- `ps2_clk` input 1 — raw PS/2 clock from the pin; asynchronous.
- `ps2_data` input 1 — raw PS/2 data from the pin; asynchronous.
- `clean_key_buffer` input 1 — pop request from the memory subsystem; may stay high for several cycles during a stall.
- `pressed_key` output 8 — FIFO head scan code; 8'h00 when empty.
- `key_valid` output 1 — FIFO non-empty.
- `overflow` output 1 — sticky; a make code was dropped because the FIFO was full.
- `frame_error` output 1 — one-cycle pulse on timeout, bad start/stop bit, or parity error (parity only with the macro, see Configuration).

## Operation
- Input sync: `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer. A falling edge is detected from a third registered copy of the clock (`sync==0 && prev==1`). The data bit is sampled from the synchronized data on the detection cycle.
- Receiver FSM, one step per detected falling edge:
  - IDLE: data=0 → DATA with bit count 0. data=1 → stay in IDLE, no error.
  - DATA: shift bits in LSB first. After 8 bits → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: data=1 and parity OK → deliver the byte. Otherwise pulse `frame_error`. Either way → IDLE.
- Timeout: the counter clears on every detected falling edge and in IDLE. In any other state, reaching `TIMEOUT_CYCLES` forces IDLE, pulses `frame_error`, and discards the partial byte.
- Code filter on each delivered byte:
  - 8'hF0: set the `brk` flag; not queued.
  - 8'hE0: not queued; no flag change.
  - Any other byte with `brk` set: not queued; clear `brk`.
  - Otherwise: push to the FIFO.
- FIFO: circular buffer with read/write pointers one bit wider than log2(FIFO_DEPTH). Full and empty come from pointer comparison.
  - Push while full: byte dropped, `overflow` set. `overflow` clears only on reset.
- Pop: fires on the rising edge of `clean_key_buffer` (high this cycle, low last cycle). Exactly one pop per assertion interval regardless of its length.
  - Pop while empty: ignored.
  - Push and pop in the same cycle when full: the pop frees a slot and the push is accepted; `overflow` is not set.
  - Push and pop in the same cycle when empty: the pop is ignored and the pushed byte remains.
- Reset (asynchronous, any time, including mid-frame): FSM → IDLE, bit count 0, `brk`=0, pointers 0, timeout counter 0, synchronizer flops 1.
  - Reset values: `pressed_key`=8'h00, `key_valid`=0, `overflow`=0, `frame_error`=0.

## Timing
- Edge detection latency: 3 CLK_CPU cycles from the pin transition (2 sync + 1 edge register).
- A queued byte appears on `pressed_key`/`key_valid` in the cycle after the STOP-bit falling edge is detected.
- `pressed_key` is combinational from the FIFO storage and read pointer (no extra register). The memory subsystem reads it in the same cycle it asserts `clean_key_buffer`.
- After a pop, the next entry (or 8'h00) is visible the following cycle.
- `frame_error` is high for exactly one cycle per error.
- Throughput: the PS/2 bit rate (10–16.7 kHz) is far below CLK_CPU, so at most one delivered byte exists per cycle.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: odd parity is required; parity over data+parity must be odd. A mismatch at STOP drops the byte and pulses `frame_error`.
- Not defined: the parity bit is sampled but ignored. Only the start and stop bits are checked.

## Test plan
- Single make code: frame for 8'h1C with correct parity and stop=1 → `key_valid`=1 and `pressed_key`=8'h1C one cycle after the stop edge. A 3-cycle `clean_key_buffer` pulse → exactly one pop, then `pressed_key`=8'h00, `key_valid`=0.
- Release filter: byte stream 1C, F0, 1C, E0, 75 → FIFO holds 1C then 75 only. Two separate pops return 1C, then 75.
- Overflow: push 9 make codes (8'h15..8'h1D) with `FIFO_DEPTH`=8 and no pops → `overflow`=1. Pops return 15..1C; 1D is lost.
- Errors: stop bit 0 → one `frame_error` pulse, nothing queued. Stop `ps2_clk` after 5 bits for 5000 cycles → `frame_error` pulse, FSM in IDLE, and the next valid frame 8'h2D is received correctly. With `PS2_PARITY_CHECK_EN`, a wrong parity bit → `frame_error`, nothing queued; without it, the byte is queued.
- Simultaneous push/pop: FIFO full, pop rising edge in the same cycle as a delivered byte → entry count stays 8, `overflow`=0, FIFO order preserved.
- Reset mid-frame: assert `RST_N` low after 4 data bits → all outputs return to their reset values immediately. After release, a full frame 8'h24 is received correctly.

Source files
------------

// File: rtl/ps2_key_buffer_if.sv
//------------------------------------------------------------------------------
// ps2_key_buffer_if
// Bundles the PS/2 pins, the pop request and the key-buffer status outputs.
//   slave  : the key buffer (samples the pins and the pop request, drives status)
//   master : the environment (drives the pins and the pop request)
// Signals:
//   ps2_clk, ps2_data  raw asynchronous PS/2 pin levels
//   clean_key_buffer   pop request from the memory subsystem (level, may stall)
//   pressed_key        FIFO head scan code, 8'h00 when empty
//   key_valid          FIFO non-empty
//   overflow           sticky, a make code was dropped on a full FIFO
//   frame_error        one-cycle pulse per receive error
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface ps2_key_buffer_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       clean_key_buffer;
   logic [7:0] pressed_key;
   logic       key_valid;
   logic       overflow;
   logic       frame_error;

   modport slave (
      input  ps2_clk,
      input  ps2_data,
      input  clean_key_buffer,
      output pressed_key,
      output key_valid,
      output overflow,
      output frame_error
   );

   modport master (
      output ps2_clk,
      output ps2_data,
      output clean_key_buffer,
      input  pressed_key,
      input  key_valid,
      input  overflow,
      input  frame_error
   );
endinterface

`default_nettype wire

// File: rtl/ps2_key_buffer.sv
//------------------------------------------------------------------------------
// ps2_key_buffer
// PS/2 keyboard receiver plus make-code FIFO. The raw PS/2 lines are
// synchronized into CLK_CPU, 11-bit frames are deframed on PS/2 clock falling
// edges, release (F0 xx) and extended-prefix (E0) codes are filtered out and
// the remaining make codes are queued. The FIFO head is presented
// combinationally; a rising edge of clean_key_buffer pops one entry.
// Ports:
//   CLK_CPU  CPU clock, all state updates on its rising edge
//   RST_N    asynchronous active-low reset
//   bus      ps2_key_buffer_if.slave (PS/2 pins, pop request, status)
// Parameters:
//   FIFO_DEPTH      queued scan codes (power of two, >= 2)
//   TIMEOUT_CYCLES  idle CLK_CPU cycles before a partial frame is abandoned
// Optional feature macro: PS2_PARITY_CHECK_EN (enforce odd parity)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ps2_key_buffer #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic              CLK_CPU,
   input  logic              RST_N,
   ps2_key_buffer_if.slave   bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_DATA   = 2'd1;
   localparam logic [1:0] c_PARITY = 2'd2;
   localparam logic [1:0] c_STOP   = 2'd3;

   localparam logic [TW-1:0] c_TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   // ---------------------------------------------------------------------
   // Input synchronizers and falling-edge detect
   // ---------------------------------------------------------------------
   logic r_clk_s1, r_clk_s2, r_clk_prev;
   logic r_dat_s1, r_dat_s2;
   logic w_fall;

   always_ff @(posedge CLK_CPU or negedge RST_N) begin
      if (!RST_N) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
      end else begin
         r_clk_s1   <= bus.ps2_clk;
         r_clk_s2   <= r_clk_s1;
         r_clk_prev <= r_clk_s2;
         r_dat_s1   <= bus.ps2_data;
         r_dat_s2   <= r_dat_s1;
      end
   end

   assign w_fall = !r_clk_s2 && r_clk_prev;

   // ---------------------------------------------------------------------
   // Frame receiver
   // ---------------------------------------------------------------------
   logic [1:0]    r_state;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic [TW-1:0] r_to_cnt;
   logic          r_frame_err;
   logic          w_timeout;
   logic          w_frame_ok;
   logic          w_deliver;

`ifdef PS2_PARITY_CHECK_EN
   logic r_parity;
   // Odd parity: data bits plus parity bit must contain an odd number of ones.
   assign w_frame_ok = r_dat_s2 && (^{r_shift, r_parity});
`else
   // Parity bit is consumed by the PARITY state but not inspected.
   assign w_frame_ok = r_dat_s2;
`endif

   // The falling edge itself clears the counter, so it never races a timeout.
   assign w_timeout = (r_state != c_IDLE) && !w_fall && (r_to_cnt == c_TO_LAST);
   assign w_deliver = w_fall && (r_state == c_STOP) && w_frame_ok;

   always_ff @(posedge CLK_CPU or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= c_IDLE;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'h00;
         r_frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         r_parity    <= 1'b0;
`endif
      end else begin
         r_frame_err <= 1'b0;
         if (w_timeout) begin
            r_state     <= c_IDLE;
            r_bit_cnt   <= 3'd0;
            r_frame_err <= 1'b1;
         end else if (w_fall) begin
            case (r_state)
               c_IDLE: begin
                  if (!r_dat_s2) begin
                     r_state   <= c_DATA;
                     r_bit_cnt <= 3'd0;
                  end
               end
               c_DATA: begin
                  // LSB arrives first, so shift in from the top.
                  r_shift   <= {r_dat_s2, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= c_PARITY;
                  end
               end
               c_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  r_parity <= r_dat_s2;
`endif
                  r_state  <= c_STOP;
               end
               c_STOP: begin
                  if (!w_frame_ok) begin
                     r_frame_err <= 1'b1;
                  end
                  r_state   <= c_IDLE;
                  r_bit_cnt <= 3'd0;
               end
               default: begin
                  r_state   <= c_IDLE;
                  r_bit_cnt <= 3'd0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge CLK_CPU or negedge RST_N) begin
      if (!RST_N) begin
         r_to_cnt <= '0;
      end else if ((r_state == c_IDLE) || w_fall || w_timeout) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Release / extended-prefix filter
   // ---------------------------------------------------------------------
   logic r_brk;
   logic w_push_req;

   assign w_push_req = w_deliver && (r_shift != 8'hF0) && (r_shift != 8'hE0) && !r_brk;

   always_ff @(posedge CLK_CPU or negedge RST_N) begin
      if (!RST_N) begin
         r_brk <= 1'b0;
      end else if (w_deliver) begin
         if (r_shift == 8'hF0) begin
            r_brk <= 1'b1;
         end else if (r_shift != 8'hE0) begin
            // The byte following F0 is the released key; it ends the break.
            r_brk <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------
   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr, r_rd_ptr;
   logic        r_clean_prev;
   logic        r_overflow;
   logic        w_empty, w_full, w_pop, w_push;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // One pop per assertion of the request, however long it is held.
   assign w_pop  = bus.clean_key_buffer && !r_clean_prev && !w_empty;
   // A same-cycle pop frees the slot the push needs.
   assign w_push = w_push_req && (!w_full || w_pop);

   always_ff @(posedge CLK_CPU or negedge RST_N) begin
      if (!RST_N) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_clean_prev <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_clean_prev <= bus.clean_key_buffer;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push_req && !w_push) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK_CPU) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
      end
   end

   assign bus.pressed_key = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
   assign bus.key_valid   = !w_empty;
   assign bus.overflow    = r_overflow;
   assign bus.frame_error = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_buffer.sv
//------------------------------------------------------------------------------
// tb_ps2_key_buffer
// Scoreboard bench for ps2_key_buffer. Stimulus drives PS/2 frames and pop
// requests and updates a queue-based reference model; expected pop results
// go to a scoreboard queue consumed by an independent monitor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_key_buffer;

   localparam int DEPTH = 8;
   localparam int HALF  = 8;   // PS/2 half bit period in CLK_CPU cycles

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct {
      bit         valid;
      logic [7:0] key;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ps2_key_buffer_if bus();

   ps2_key_buffer #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (5000)
   ) dut (
      .CLK_CPU (clk),
      .RST_N   (rst_n),
      .bus     (bus.slave)
   );

   int n_total = 0;
   int n_pass  = 0;

   // Reference model
   logic [7:0] m_q[$];
   bit         m_brk = 1'b0;
   bit         m_ovf = 1'b0;
   int         m_err = 0;
   exp_t       sb_q[$];
   int         err_seen = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ------------------------------------------------------------------
   // Monitor: pops scoreboard entries on each pop request rising edge
   // ------------------------------------------------------------------
   logic mon_clean_prev = 1'b0;
   logic mon_fe_prev    = 1'b0;
   exp_t mon_e;

   always @(negedge clk) begin
      if (bus.clean_key_buffer && !mon_clean_prev) begin
         if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL pop_unexpected: got pop request with no expected entry");
         end else begin
            mon_e = sb_q.pop_front();
            check("pop_valid", int'(bus.key_valid), int'(mon_e.valid));
            check("pop_key", int'(bus.pressed_key), int'(mon_e.key));
         end
      end
      mon_clean_prev = bus.clean_key_buffer;
      if (bus.frame_error === 1'b1) begin
         err_seen++;
         if (mon_fe_prev) begin
            n_total++;
            $display("FAIL frame_error_width: got high for 2+ cycles expected 1");
         end
      end
      mon_fe_prev = (bus.frame_error === 1'b1);
   end

   // ------------------------------------------------------------------
   // Model operations
   // ------------------------------------------------------------------
   function automatic void model_deliver(input logic [7:0] b);
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) begin end
      else if (m_brk) m_brk = 1'b0;
      else if (m_q.size() < DEPTH) m_q.push_back(b);
      else m_ovf = 1'b1;
   endfunction

   function automatic void model_pop();
      exp_t e;
      if (m_q.size() > 0) begin
         e.valid = 1'b1;
         e.key   = m_q.pop_front();
      end else begin
         e.valid = 1'b0;
         e.key   = 8'h00;
      end
      sb_q.push_back(e);
   endfunction

   function automatic void model_reset();
      m_q.delete();
      m_brk = 1'b0;
      m_ovf = 1'b0;
   endfunction

   task automatic check_state(input string tag);
      check({tag, "_key_valid"}, int'(bus.key_valid), int'(m_q.size() > 0));
      check({tag, "_pressed_key"}, int'(bus.pressed_key),
            (m_q.size() > 0) ? int'(m_q[0]) : 0);
      check({tag, "_overflow"}, int'(bus.overflow), int'(m_ovf));
      check({tag, "_frame_errors"}, err_seen, m_err);
   endtask

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   // Drives the first nbits bits of a frame. With pop_at_stop the pop request
   // rises in the same cycle the receiver sees the stop-bit falling edge.
   task automatic send_bits(input logic [7:0] b, input bit bad_stop, input bit bad_par,
                            input int nbits, input bit pop_at_stop);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data = f[i];
         repeat (HALF) @(posedge clk);
         #1 bus.ps2_clk = 1'b0;
         if (i == 10 && pop_at_stop) begin
            repeat (2) @(posedge clk);
            #1;
            model_pop();
            bus.clean_key_buffer = 1'b1;
            repeat (HALF - 2) @(posedge clk);
         end else begin
            repeat (HALF) @(posedge clk);
         end
         #1 bus.ps2_clk = 1'b1;
      end
      bus.ps2_data = 1'b1;
      repeat (HALF) @(posedge clk);
      #1 bus.clean_key_buffer = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [7:0] b, input bit bad_stop, input bit bad_par,
                        input bit pop_at_stop);
      send_bits(b, bad_stop, bad_par, 11, pop_at_stop);
      if (bad_stop || (PAR_EN && bad_par)) m_err++;
      else model_deliver(b);
   endtask

   task automatic pop(input int len);
      @(posedge clk);
      #1;
      model_pop();
      bus.clean_key_buffer = 1'b1;
      repeat (len) @(posedge clk);
      #1 bus.clean_key_buffer = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      logic [7:0] b;
      int r;
      bus.ps2_clk          = 1'b1;
      bus.ps2_data         = 1'b1;
      bus.clean_key_buffer = 1'b0;
      rst_n                = 1'b0;
      repeat (4) @(posedge clk);
      #1 check_state("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single make code, then a held 3-cycle pop
      frame(8'h1C, 0, 0, 0);
      check_state("single");
      pop(3);
      check_state("single_popped");

      // Release and extended-prefix filtering
      frame(8'h1C, 0, 0, 0);
      frame(8'hF0, 0, 0, 0);
      frame(8'h1C, 0, 0, 0);
      frame(8'hE0, 0, 0, 0);
      frame(8'h75, 0, 0, 0);
      check_state("filter");
      pop(1);
      pop(1);
      check_state("filter_drained");

      // Overflow: nine codes into an eight-deep FIFO
      for (int i = 0; i < 9; i++) frame(8'h15 + 8'(i), 0, 0, 0);
      check_state("overflow");
      for (int i = 0; i < 9; i++) pop(2);
      check_state("overflow_drained");

      // Bad stop bit
      frame(8'h3A, 1, 0, 0);
      check_state("bad_stop");

      // Timeout on a partial frame, then recovery
      send_bits(8'hAA, 0, 0, 6, 0);
      repeat (5200) @(posedge clk);
      #1 m_err++;
      check_state("timeout");
      frame(8'h2D, 0, 0, 0);
      check_state("after_timeout");
      pop(1);

      // Wrong parity bit
      frame(8'h33, 0, 1, 0);
      check_state("bad_parity");
      pop(1);

      // Reset in the middle of a frame
      frame(8'h11, 0, 0, 0);
      send_bits(8'h5B, 0, 0, 5, 0);
      #3 rst_n = 1'b0;
      #1 model_reset();
      check_state("mid_reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      frame(8'h24, 0, 0, 0);
      check_state("after_reset");
      pop(1);

      // Full FIFO with pop and push in the same cycle
      for (int i = 0; i < DEPTH; i++) frame(8'h40 + 8'(i), 0, 0, 0);
      frame(8'h48, 0, 0, 1);
      check_state("simul");
      check("simul_count", int'(m_q.size()), DEPTH);
      for (int i = 0; i < DEPTH; i++) pop(1);
      check_state("simul_drained");

      // Randomized traffic
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 6) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 6) == 0) b = ($urandom_range(0, 1) != 0) ? 8'hF0 : 8'hE0;
            frame(b, (r == 6), ($urandom_range(0, 9) == 0), 0);
         end else begin
            pop($urandom_range(1, 4));
         end
         check_state("random");
      end
      while (m_q.size() > 0) pop(1);
      pop(1);
      check_state("final");
      check("scoreboard_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
